// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM state encoding and saturation limits for the multi-cycle ALU.
package alu_mc_pkg;

    localparam logic [5:0] OP_SLL  = 6'h00;
    localparam logic [5:0] OP_SRL  = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_MUL  = 6'h18;
    localparam logic [5:0] OP_ADD  = 6'h20;
    localparam logic [5:0] OP_SUB  = 6'h22;
    localparam logic [5:0] OP_AND  = 6'h24;
    localparam logic [5:0] OP_OR   = 6'h25;
    localparam logic [5:0] OP_NOR  = 6'h27;
    localparam logic [5:0] OP_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_e;

    // Limits are produced 64 bits wide; callers size-cast to their width (w <= 64).
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/result handshake bundle between decode, the ALU and writeback.
interface alu_mc_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned OPCODE_WIDTH = 6
);
    logic                    i_in_valid;
    logic                    o_in_ready;
    logic [OPCODE_WIDTH-1:0] i_op_mode;
    logic [DATA_WIDTH-1:0]   i_data_a;
    logic [DATA_WIDTH-1:0]   i_data_b;
    logic                    o_out_valid;
    logic                    i_out_ready;
    logic [DATA_WIDTH-1:0]   o_data;
    logic                    o_overflow;

    modport master (
        output i_in_valid, i_op_mode, i_data_a, i_data_b, i_out_ready,
        input  o_in_ready, o_out_valid, o_data, o_overflow
    );

    modport slave (
        input  i_in_valid, i_op_mode, i_data_a, i_data_b, i_out_ready,
        output o_in_ready, o_out_valid, o_data, o_overflow
    );
endinterface

// File: rtl/alu_iter_mul.sv
// Iterative unsigned shift-add multiplier retiring MUL_BITS_PER_CYCLE multiplier bits per cycle.
module alu_iter_mul #(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic                      busy,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   product
);
    localparam int unsigned N  = DATA_WIDTH / MUL_BITS_PER_CYCLE;
    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
    logic [2*DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;

    always_comb begin
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start) begin
            cnt_d    = '0;
            busy_d   = 1'b1;
            acc_d    = '0;
            mcand_d  = {{DATA_WIDTH{1'b0}}, a};
            mplier_d = b;
        end else if (busy_q) begin
            for (int unsigned j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
                if (mplier_q[j]) acc_d = acc_d + (mcand_q << j);
            end
            mcand_d  = mcand_q << MUL_BITS_PER_CYCLE;
            mplier_d = mplier_q >> MUL_BITS_PER_CYCLE;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc_q;
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle handshaked integer ALU; single-cycle simple ops, iterative MUL.
// Define ALU_MC_SAT_EN to clamp overflowing ADD/SUB/MUL results instead of wrapping.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned OPCODE_WIDTH       = 6,
    parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    alu_mc_if.slave  bus
);
    localparam int unsigned W = DATA_WIDTH;
    localparam logic [W-1:0] W_VAL = W'(DATA_WIDTH);

    state_e state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic         ovf_q, ovf_d;
    logic         neg_q, neg_d;

    logic [OPCODE_WIDTH-1:0] op;
    logic [W-1:0]   a, b, mag_a, mag_b;
    logic           in_ready, accept, is_mul, mul_start, mul_busy, mul_done;
    logic [2*W-1:0] mul_prod, mul_signed;
    logic [W:0]     sum_ext;
    logic [W-1:0]   simple_res, mul_res;
    logic           simple_ovf, mul_ovf;

    assign op       = bus.i_op_mode;
    assign a        = bus.i_data_a;
    assign b        = bus.i_data_b;
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.i_out_ready);
    assign accept   = bus.i_in_valid && in_ready;
    assign is_mul   = (op == OPCODE_WIDTH'(OP_MUL));
    assign mag_a    = a[W-1] ? ('0 - a) : a;
    assign mag_b    = b[W-1] ? ('0 - b) : b;

    alu_iter_mul #(
        .DATA_WIDTH        (DATA_WIDTH),
        .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
    ) u_mul (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .start  (mul_start),
        .a      (mag_a),
        .b      (mag_b),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_prod)
    );

    always_comb begin
        simple_res = '0;
        simple_ovf = 1'b0;
        sum_ext    = '0;
        case (op)
            OPCODE_WIDTH'(OP_ADD), OPCODE_WIDTH'(OP_ADDI): begin
                sum_ext    = {a[W-1], a} + {b[W-1], b};
                simple_res = sum_ext[W-1:0];
                simple_ovf = sum_ext[W] ^ sum_ext[W-1];
            end
            OPCODE_WIDTH'(OP_SUB): begin
                sum_ext    = {a[W-1], a} - {b[W-1], b};
                simple_res = sum_ext[W-1:0];
                simple_ovf = sum_ext[W] ^ sum_ext[W-1];
            end
            OPCODE_WIDTH'(OP_AND): simple_res = a & b;
            OPCODE_WIDTH'(OP_OR):  simple_res = a | b;
            OPCODE_WIDTH'(OP_NOR): simple_res = ~(a | b);
            OPCODE_WIDTH'(OP_SLT): simple_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OPCODE_WIDTH'(OP_BEQ): simple_res = {W{a == b}};
            OPCODE_WIDTH'(OP_BNE): simple_res = {W{a != b}};
            OPCODE_WIDTH'(OP_SLL): simple_res = (b >= W_VAL) ? '0 : (a << b);
            OPCODE_WIDTH'(OP_SRL): simple_res = (b >= W_VAL) ? '0 : (a >> b);
            default: ;
        endcase
`ifdef ALU_MC_SAT_EN
        // The extra sum bit carries the sign of the exact result.
        if (simple_ovf) simple_res = sum_ext[W] ? W'(sat_min(W)) : W'(sat_max(W));
`endif
    end

    always_comb begin
        mul_signed = neg_q ? ('0 - mul_prod) : mul_prod;
        mul_ovf    = !((&mul_signed[2*W-1:W-1]) || !(|mul_signed[2*W-1:W-1]));
        mul_res    = mul_signed[W-1:0];
`ifdef ALU_MC_SAT_EN
        if (mul_ovf) mul_res = neg_q ? W'(sat_min(W)) : W'(sat_max(W));
`endif
    end

    // S_DONE with a consumer handshake behaves like S_IDLE so a new op lands in the same cycle.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        ovf_d     = ovf_q;
        neg_d     = neg_q;
        mul_start = 1'b0;
        case (state_q)
            S_MUL: begin
                if (mul_done && !mul_busy) begin
                    state_d = S_DONE;
                    data_d  = mul_res;
                    ovf_d   = mul_ovf;
                end
            end
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE && bus.i_out_ready) state_d = S_IDLE;
                if (accept) begin
                    if (is_mul) begin
                        state_d   = S_MUL;
                        mul_start = 1'b1;
                        neg_d     = a[W-1] ^ b[W-1];
                    end else begin
                        state_d = S_DONE;
                        data_d  = simple_res;
                        ovf_d   = simple_ovf;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.o_in_ready  = in_ready;
    assign bus.o_out_valid = (state_q == S_DONE);
    assign bus.o_data      = data_q;
    assign bus.o_overflow  = ovf_q;
endmodule
